step_sequencer_ctrl: RTL and testbench
======================================

Name: step_sequencer_ctrl

Overview:
Parametrised step sequencer and tone generator for the picoversat sound peripheral, clk = 50 MHz. Holds a STEPS-entry pattern of note codes. Plays the pattern once or in a loop at a programmable step length, or plays a live keyboard note while idle. Drives a square-wave snd_out and a one-hot step indicator on the LEDs.

Parameters:
STEPS, 8, pattern length; power of two, >= 2
NOTE_W, 8, note code width; code 0 = rest
HP_SCALE, 500, clk cycles per note-code unit of half-period (note 50 -> 1 kHz, note 250 -> 200 Hz)
TONE_W, 17, tone counter width; must hold (2^NOTE_W-1)*HP_SCALE
TICK_W, 26, step-length counter width

Ports:
clk  in  1  clock
rst  in  1  reset
wr_en  in  1  pattern write strobe
wr_addr  in  $clog2(STEPS)  pattern write index
wr_data  in  NOTE_W  note code to store
step_ticks  in  TICK_W  clk cycles per step; 0 is treated as 1
start  in  1  one-cycle start of playback
stop  in  1  one-cycle abort of playback
loop_en  in  1  wrap to step 0 after the last step
live_en  in  1  sound live_note while idle
live_note  in  NOTE_W  keyboard note code
snd_out  out  1  square-wave audio
led_out  out  STEPS  one-hot current step during playback, else 0
busy  out  1  high in PLAY
done  out  1  one-cycle pulse at natural end of playback

Behaviour:
- Reset is asynchronous, active-high: rst, clock clk. All flops clear: state=IDLE, step=0, counters=0, pattern entries=0, snd_out=0, led_out=0, busy=0, done=0. All outputs are registered.
- Pattern write: when wr_en=1, pattern[wr_addr] <= wr_data at the clock edge, in any state. A write to the currently playing step affects sound only at that step's next load.
- States: IDLE, PLAY.
- IDLE -> PLAY:
  - start=1 and stop=0: next cycle state=PLAY, step=0, tick count reloaded from step_ticks, current note loaded from pattern[0], busy=1, led_out=1<<0.
  - start is ignored in PLAY; it does not restart playback.
- PLAY:
  - Step boundary: the tick counter counts down from max(step_ticks,1)-1 and is sampled at each step load. At 0 the step ends.
  - Normal advance: if step<STEPS-1, step+1 is loaded on the next edge.
  - Last step with loop_en=1: wrap to step 0 with no gap cycle.
  - Last step with loop_en=0: state=IDLE, done=1 for exactly one cycle, busy=0, led_out=0. loop_en is sampled only at that boundary.
  - stop=1 forces IDLE on the next edge with no done pulse and snd_out=0. stop and start in the same cycle: stop wins.
- Tone generation:
  - Active note: the pattern note in PLAY; live_note in IDLE when live_en=1; otherwise rest.
  - Half-period = note*HP_SCALE cycles. The tone counter increments each cycle; at half-period-1 it clears and snd_out toggles.
  - Any change of the active note (step load, live_note change, mode change) clears the tone counter and drives snd_out=0 in that cycle.
  - Rest (note 0) holds snd_out=0.
  - live_en is ignored during PLAY.
- Reset mid-playback: immediate return to IDLE, all outputs 0. The pattern is lost and reads as 0.

Decomposition:
- Package seq_pkg: state encoding (IDLE, PLAY), NOTE_REST=0, default HP_SCALE and TICK_W constants.
- Sub-module sequencer_tone_gen (note, scale, restart -> snd_out): the counter and toggle logic. The top level holds the FSM, step/tick counters and pattern registers.

Test Plan:
Bench parameters STEPS=4, HP_SCALE=2, step_ticks=100.
- Reset: assert rst asynchronously mid-cycle -> all outputs 0 immediately; state IDLE.
- Write pattern {5,0,10,5}, start with loop_en=0:
  - led_out = 0001, 0010, 0100, 1000 for 100 cycles each.
  - snd_out period: 20 cycles in step 0, constant 0 in step 1, 40 cycles in step 2.
  - After step 3 ends: done=1 for 1 cycle, busy=0.
- Same pattern with loop_en=1 for 900 cycles -> step 3 is followed directly by step 0 with no gap; done never asserts.
- stop in step 2 with start asserted in the same cycle -> IDLE next edge; snd_out=0, led_out=0, no done.
- IDLE with live_en=1, live_note=5, then 10 -> period 20 cycles, then counter restarts and period is 40 cycles. start then ignores live_note.
- step_ticks=0 -> each step lasts 1 cycle. Write pattern[1]=7 while step 1 is playing -> new value is heard on the next pass.

Source files
------------

// File: rtl/seq_pkg.sv
// Shared types and defaults for the step sequencer / tone generator.
package seq_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    PLAY = 1'b1
  } seq_state_e;

  localparam int unsigned NOTE_REST    = 0;
  localparam int unsigned HP_SCALE_DEF = 500;
  localparam int unsigned TICK_W_DEF   = 26;
  localparam int unsigned TONE_W_DEF   = 17;

endpackage

// File: rtl/sequencer_tone_gen.sv
// Square-wave generator: half-period = note * HP_SCALE cycles, cleared on restart or rest.
module sequencer_tone_gen
  import seq_pkg::*;
#(
  parameter int unsigned NOTE_W   = 8,
  parameter int unsigned TONE_W   = TONE_W_DEF,
  parameter int unsigned HP_SCALE = HP_SCALE_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NOTE_W-1:0] note,
  input  logic              restart,
  output logic              snd_out
);

  logic [TONE_W-1:0] cnt;
  logic [TONE_W-1:0] half_m1;

  // Only meaningful for nonzero notes; rest is handled before the compare.
  assign half_m1 = TONE_W'(note) * TONE_W'(HP_SCALE) - TONE_W'(1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt     <= '0;
      snd_out <= 1'b0;
    end else if (restart || (note == NOTE_W'(NOTE_REST))) begin
      cnt     <= '0;
      snd_out <= 1'b0;
    end else if (cnt == half_m1) begin
      cnt     <= '0;
      snd_out <= ~snd_out;
    end else begin
      cnt <= cnt + TONE_W'(1);
    end
  end

endmodule

// File: rtl/step_sequencer_ctrl.sv
// Step sequencer: pattern store, PLAY/IDLE control, step timing and note selection.
module step_sequencer_ctrl
  import seq_pkg::*;
#(
  parameter int unsigned STEPS    = 8,
  parameter int unsigned NOTE_W   = 8,
  parameter int unsigned HP_SCALE = HP_SCALE_DEF,
  parameter int unsigned TONE_W   = TONE_W_DEF,
  parameter int unsigned TICK_W   = TICK_W_DEF
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_en,
  input  logic [$clog2(STEPS)-1:0] wr_addr,
  input  logic [NOTE_W-1:0]        wr_data,
  input  logic [TICK_W-1:0]        step_ticks,
  input  logic                     start,
  input  logic                     stop,
  input  logic                     loop_en,
  input  logic                     live_en,
  input  logic [NOTE_W-1:0]        live_note,
  output logic                     snd_out,
  output logic [STEPS-1:0]         led_out,
  output logic                     busy,
  output logic                     done
);

  localparam int unsigned SW = $clog2(STEPS);
  localparam logic [SW-1:0] LAST_STEP = SW'(STEPS - 1);

  seq_state_e        state, state_nxt;
  logic [SW-1:0]     step, step_nxt;
  logic [TICK_W-1:0] tick, tick_nxt, tick_load;
  logic [NOTE_W-1:0] cur_note, note_nxt, idle_note;
  logic [NOTE_W-1:0] pattern [STEPS];
  logic [STEPS-1:0]  led_nxt;
  logic              busy_nxt, done_nxt;
  logic              load, mode_chg, restart;

  // Pattern store, writable in any state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < STEPS; i++) pattern[i] <= '0;
    end else if (wr_en) begin
      pattern[wr_addr] <= wr_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      step     <= '0;
      tick     <= '0;
      cur_note <= '0;
      led_out  <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      state    <= state_nxt;
      step     <= step_nxt;
      tick     <= tick_nxt;
      cur_note <= note_nxt;
      led_out  <= led_nxt;
      busy     <= busy_nxt;
      done     <= done_nxt;
    end
  end

  // Next state, step timing and the note that will sound next cycle.
  always_comb begin
    state_nxt = state;
    step_nxt  = step;
    tick_nxt  = tick;
    note_nxt  = cur_note;
    led_nxt   = led_out;
    busy_nxt  = busy;
    done_nxt  = 1'b0;
    load      = 1'b0;
    mode_chg  = 1'b0;
    tick_load = (step_ticks == '0) ? '0 : step_ticks - TICK_W'(1);
    idle_note = live_en ? live_note : NOTE_W'(NOTE_REST);

    case (state)
      IDLE: begin
        note_nxt = idle_note;
        if (start && !stop) begin
          state_nxt = PLAY;
          step_nxt  = '0;
          busy_nxt  = 1'b1;
          load      = 1'b1;
        end
      end
      PLAY: begin
        if (stop) begin
          state_nxt = IDLE;
          mode_chg  = 1'b1;
        end else if (tick == '0) begin
          if (step != LAST_STEP) begin
            step_nxt = step + SW'(1);
            load     = 1'b1;
          end else if (loop_en) begin
            step_nxt = '0;
            load     = 1'b1;
          end else begin
            state_nxt = IDLE;
            done_nxt  = 1'b1;
            mode_chg  = 1'b1;
          end
        end else begin
          tick_nxt = tick - TICK_W'(1);
        end
        if (state_nxt == IDLE) begin
          busy_nxt = 1'b0;
          led_nxt  = '0;
          note_nxt = idle_note;
        end
      end
    endcase

    if (load) begin
      tick_nxt = tick_load;
      note_nxt = pattern[step_nxt];
      led_nxt  = STEPS'(1) << step_nxt;
    end

    // Every step load or mode switch restarts the tone, even with an unchanged note.
    restart = load || mode_chg || (note_nxt != cur_note);
  end

  sequencer_tone_gen #(
    .NOTE_W  (NOTE_W),
    .TONE_W  (TONE_W),
    .HP_SCALE(HP_SCALE)
  ) u_tone (
    .clk    (clk),
    .rst    (rst),
    .note   (note_nxt),
    .restart(restart),
    .snd_out(snd_out)
  );

endmodule

// File: tb/tb_step_sequencer_ctrl.sv
// Bench for step_sequencer_ctrl: directed phases plus random traffic against a timeline model.
module tb_step_sequencer_ctrl;

  localparam int unsigned STEPS    = 4;
  localparam int unsigned NOTE_W   = 8;
  localparam int unsigned HP_SCALE = 2;
  localparam int unsigned TONE_W   = 17;
  localparam int unsigned TICK_W   = 26;
  localparam int unsigned AW       = 2;

  logic              clk = 1'b0;
  logic              rst;
  logic              wr_en;
  logic [AW-1:0]     wr_addr;
  logic [NOTE_W-1:0] wr_data;
  logic [TICK_W-1:0] step_ticks;
  logic              start, stop, loop_en, live_en;
  logic [NOTE_W-1:0] live_note;
  logic              snd_out, busy, done;
  logic [STEPS-1:0]  led_out;

  int n_vec = 0;
  int n_err = 0;
  int done_seen;

  // Model: play flag, step index, cycles elapsed in step, step length, sounding note, cycles since tone start.
  bit m_play, m_done;
  int m_step, m_e, m_len, m_note, m_t;
  int m_pat [STEPS];

  step_sequencer_ctrl #(
    .STEPS(STEPS), .NOTE_W(NOTE_W), .HP_SCALE(HP_SCALE), .TONE_W(TONE_W), .TICK_W(TICK_W)
  ) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .step_ticks(step_ticks), .start(start), .stop(stop), .loop_en(loop_en),
    .live_en(live_en), .live_note(live_note), .snd_out(snd_out), .led_out(led_out),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string ph, input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s/%s observed=%0h expected=%0h", ph, tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_play = 0; m_done = 0; m_step = 0; m_e = 0; m_len = 1; m_note = 0; m_t = 0;
    for (int i = 0; i < STEPS; i++) m_pat[i] = 0;
  endtask

  // Advance the model by one clock using the inputs present at that edge.
  task automatic model_update();
    int  nstep, nnote, len;
    bit  nplay, load, chg, ndone;
    nstep = m_step; nplay = m_play; load = 0; chg = 0; ndone = 0;
    len = (step_ticks == 0) ? 1 : int'(step_ticks);
    if (!m_play) begin
      if (start && !stop) begin nplay = 1; nstep = 0; load = 1; end
    end else if (stop) begin
      nplay = 0; chg = 1;
    end else if (m_e == m_len - 1) begin
      if (m_step < STEPS - 1)  begin nstep = m_step + 1; load = 1; end
      else if (loop_en)        begin nstep = 0; load = 1; end
      else                     begin nplay = 0; ndone = 1; chg = 1; end
    end
    if (nplay) nnote = load ? m_pat[nstep] : m_note;
    else       nnote = live_en ? int'(live_note) : 0;
    if (wr_en) m_pat[wr_addr] = int'(wr_data);
    if (load) begin m_e = 0; m_len = len; end
    else m_e++;
    m_t    = (load || chg || nnote != m_note) ? 0 : m_t + 1;
    m_play = nplay; m_step = nstep; m_done = ndone; m_note = nnote;
  endtask

  function automatic logic exp_snd();
    if (m_note == 0) return 1'b0;
    return logic'((m_t / (m_note * int'(HP_SCALE))) % 2);
  endfunction

  task automatic check_all(input string ph);
    chk(ph, "snd_out", 32'(snd_out), 32'(exp_snd()));
    chk(ph, "led_out", 32'(led_out), m_play ? 32'(1 << m_step) : 32'd0);
    chk(ph, "busy",    32'(busy),    32'(m_play));
    chk(ph, "done",    32'(done),    32'(m_done));
  endtask

  task automatic cyc(input string ph);
    @(posedge clk);
    model_update();
    @(negedge clk);
    if (done === 1'b1) done_seen++;
    check_all(ph);
  endtask

  task automatic wr(input int a, input int d);
    wr_en = 1'b1; wr_addr = AW'(a); wr_data = NOTE_W'(d);
    cyc("write");
    wr_en = 1'b0;
  endtask

  initial begin
    rst = 1'b1; wr_en = 0; wr_addr = '0; wr_data = '0; step_ticks = TICK_W'(100);
    start = 0; stop = 0; loop_en = 0; live_en = 0; live_note = '0;
    model_reset();
    repeat (3) @(negedge clk);
    check_all("reset");
    rst = 1'b0;

    wr(0, 5); wr(1, 0); wr(2, 10); wr(3, 5);

    // Single pass: four 100-cycle steps then one done pulse.
    done_seen = 0;
    start = 1; cyc("once"); start = 0;
    chk("once", "led_first", 32'(led_out), 32'd1);
    repeat (410) cyc("once");
    chk("once", "done_count", 32'(done_seen), 32'd1);

    // Looping: step 3 wraps straight to step 0, no done.
    done_seen = 0; loop_en = 1;
    start = 1; cyc("loop"); start = 0;
    repeat (900) cyc("loop");
    chk("loop", "done_count", 32'(done_seen), 32'd0);

    // Abort during step 2 with start in the same cycle.
    for (int i = 0; i < 500 && !(m_play && m_step == 2 && m_e == 50); i++) cyc("seek2");
    chk("stop", "led_at_stop", 32'(led_out), 32'd4);
    done_seen = 0;
    start = 1; stop = 1; cyc("stop"); start = 0; stop = 0;
    chk("stop", "led_after", 32'(led_out), 32'd0);
    chk("stop", "snd_after", 32'(snd_out), 32'd0);
    repeat (5) cyc("stop");
    chk("stop", "done_count", 32'(done_seen), 32'd0);

    // Live keyboard note in IDLE, then a start takes over.
    loop_en = 0; live_en = 1; live_note = NOTE_W'(5);
    repeat (100) cyc("live5");
    live_note = NOTE_W'(10);
    repeat (200) cyc("live10");
    start = 1; cyc("live_start"); start = 0;
    repeat (150) cyc("live_ign");
    live_note = NOTE_W'(3);
    repeat (300) cyc("live_ign");

    // One-cycle steps; rewrite step 1 while it plays.
    live_en = 0; step_ticks = '0; loop_en = 1;
    start = 1; cyc("tick0"); start = 0;
    for (int i = 0; i < 10 && !(m_play && m_step == 0); i++) cyc("tick0");
    chk("tick0", "led_step0", 32'(led_out), 32'd1);
    cyc("tick0");
    chk("tick0", "led_step1", 32'(led_out), 32'd2);
    wr_en = 1; wr_addr = AW'(1); wr_data = NOTE_W'(7); cyc("tick0_wr"); wr_en = 0;
    repeat (12) cyc("tick0");
    stop = 1; cyc("tick0"); stop = 0;

    // Random traffic.
    step_ticks = TICK_W'(8);
    for (int i = 0; i < 3000; i++) begin
      wr_en   = ($urandom_range(0, 3) == 0);
      wr_addr = AW'($urandom_range(0, STEPS - 1));
      wr_data = NOTE_W'($urandom_range(0, 12));
      start   = ($urandom_range(0, 19) == 0);
      stop    = ($urandom_range(0, 59) == 0);
      if ($urandom_range(0, 29) == 0) loop_en = ~loop_en;
      if ($urandom_range(0, 49) == 0) live_en = ~live_en;
      if ($urandom_range(0, 39) == 0) live_note = NOTE_W'($urandom_range(0, 12));
      if ($urandom_range(0, 99) == 0) step_ticks = TICK_W'($urandom_range(0, 30));
      cyc("random");
    end
    wr_en = 0; start = 0; stop = 0; live_en = 0; loop_en = 0;

    // Asynchronous reset mid-playback clears outputs at once and wipes the pattern.
    wr(0, 3); wr(1, 3); wr(2, 3); wr(3, 3);
    step_ticks = TICK_W'(20);
    start = 1; cyc("pre_rst"); start = 0;
    repeat (15) cyc("pre_rst");
    #2 rst = 1'b1;
    #1;
    model_reset();
    check_all("async_rst");
    @(negedge clk);
    rst = 1'b0;
    start = 1; cyc("post_rst"); start = 0;
    repeat (40) cyc("post_rst");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
